bus_addr_dec: RTL

Parametrised, registered address decoder for the single-master system bus. It maps a master address onto one of NUM_SLV slave windows and drives a one-hot slave select one cycle after the request is sampled. It adds decode-error detection, error-address capture, a saturating error counter and a per-transaction state machine. It replaces the two-slave combinational decoder between the master and the RAM, Factorial Core and future slaves.

---
 rtl/bus_addr_dec_if.sv | 14 +
 rtl/bus_addr_dec.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bus_addr_dec_if.sv
// Master-side bus between the system master and the address decoder.
// The decoder takes the slave modport and drives the slave selects back.
interface bus_addr_dec_if #(
    parameter int NUM_SLV = 2,
    parameter int ADDR_W  = 16
);
    logic                m_req;
    logic [ADDR_W-1:0]   m_addr;
    logic [NUM_SLV-1:0]  s_sel;
    logic [2:0]          s_idx;

    modport master (output m_req, m_addr, input  s_sel, s_idx);
    modport slave  (input  m_req, m_addr, output s_sel, s_idx);
endinterface

// File: rtl/bus_addr_dec.sv
// Registered address decoder: maps m_addr onto NUM_SLV windows and drives a
// one-hot select one cycle later, with decode-miss capture and counting.
module bus_addr_dec #(
    parameter int                        NUM_SLV   = 2,
    parameter int                        ADDR_W    = 16,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE  = {16'h7000, 16'h0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_LAST  = {16'h71FF, 16'h07FF},
    parameter int                        ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bus_addr_dec_if.slave        bus,
    input  logic                 err_clr,
    output logic                 dec_err,
    output logic                 err_sticky,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [NUM_SLV-1:0]     sel_reg;
    logic [2:0]             idx_reg;
    logic                   dec_err_reg;
    logic                   err_sticky_reg;
    logic [ADDR_W-1:0]      err_addr_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;

    logic [NUM_SLV-1:0]     hit_vec;
    logic [NUM_SLV-1:0]     sel_next;
    logic [2:0]             idx_next;
    logic                   any_hit;

    // Offset range check: base <= addr <= last is equivalent to
    // (addr - base) <= (last - base) in modulo arithmetic when base <= last.
    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_win
            logic [ADDR_W-1:0] offset;
            logic [ADDR_W-1:0] span;
            assign offset      = bus.m_addr - SLV_BASE[gi*ADDR_W +: ADDR_W];
            assign span        = SLV_LAST[gi*ADDR_W +: ADDR_W] - SLV_BASE[gi*ADDR_W +: ADDR_W];
            assign hit_vec[gi] = (offset <= span);
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        sel_next = '0;
        idx_next = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel_next    = '0;
                sel_next[i] = 1'b1;
                idx_next    = 3'(i);
            end
        end
    end

    assign any_hit = |hit_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            idx_reg        <= '0;
            dec_err_reg    <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_addr_reg   <= '0;
            err_cnt_reg    <= '0;
        end else begin
            dec_err_reg <= 1'b0;
            if (err_clr) begin
                err_sticky_reg <= 1'b0;
                err_cnt_reg    <= '0;
            end
            case (state_reg)
                IDLE, SEL, ERR: begin
                    if (!bus.m_req) begin
                        state_reg <= IDLE;
                        sel_reg   <= '0;
                        idx_reg   <= '0;
                    end else if (any_hit) begin
                        state_reg <= SEL;
                        sel_reg   <= sel_next;
                        idx_reg   <= idx_next;
                    end else begin
                        state_reg <= ERR;
                        sel_reg   <= '0;
                        idx_reg   <= '0;
                        // A miss is recorded only on entry; a held miss stays silent.
                        if (state_reg != ERR) begin
                            dec_err_reg    <= 1'b1;
                            err_sticky_reg <= 1'b1;
                            err_addr_reg   <= bus.m_addr;
                            if (err_clr)
                                err_cnt_reg <= ERR_CNT_W'(1);
                            else if (err_cnt_reg != '1)
                                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    sel_reg   <= '0;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.s_sel  = sel_reg;
    assign bus.s_idx  = idx_reg;
    assign dec_err    = dec_err_reg;
    assign err_sticky = err_sticky_reg;
    assign err_addr   = err_addr_reg;
    assign err_cnt    = err_cnt_reg;
endmodule
